mul_add2_stage: RTL and testbench
=================================

Name: mul_add2_stage

Overview:
- Lane-parallel fixed-point multiply-add stage that sits directly upstream of the mul_add2 previous-result register.
- Computes result[i] = prev[i] ± scalar*vec[i] for every lane of a cluster vector.
- prev[i] is read back from the register's memory_output; the result is written into the register through its write_enable.
- Processes a burst of beat_count vectors per start command, so the register accumulates across beats, with an interlock so each beat sees the previous beat's committed result.

Parameters:
number_of_equations_per_cluster, 9, lanes per vector (N)
element_width, 32, signed two's-complement lane width (W)
frac_bits, 16, fractional bits of fixed-point format (F, 1..W-1)
count_width, 16, width of beat_count

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous active-high reset
start  in  1  one-cycle burst start; honoured only in IDLE
beat_count  in  count_width  beats in burst, sampled on start
scalar  in  W  signed multiplier, sampled on start, held for burst
subtract  in  1  1: prev - product, 0: prev + product; sampled on start
in_valid  in  1  in_vector valid
in_ready  out  1  beat accepted on clk edge when in_valid & in_ready
in_vector  in  W*N  lane i at bits [W*i +: W]
prev_vector  in  W*N  from downstream memory_output
result_data  out  W*N  to downstream input_data
result_write_enable  out  1  to downstream write_enable; one cycle per beat
busy  out  1  state != IDLE
done  out  1  one-cycle pulse at burst completion
overflow  out  1  sticky saturation flag (see Optional Feature)

Behaviour:
- Reset values: in_ready=0, result_data=0, result_write_enable=0, busy=0, done=0, overflow=0. FSM=IDLE, pipeline valids cleared, remaining=0.
- Reset mid-burst aborts immediately. Beats in flight are discarded and no write_enable is issued afterwards.
- FSM IDLE:
  - start & beat_count!=0 → RUN; latch scalar, subtract and remaining=beat_count.
  - start & beat_count==0 → stay IDLE; done=1 on the next cycle.
- FSM RUN:
  - in_ready=1 except in the cycle immediately following an accept (mandatory one-cycle bubble).
  - Each accept decrements remaining. Accepting the beat that brings remaining to 0 → DRAIN.
- FSM DRAIN: in_ready=0. When the last beat's result_write_enable is high → IDLE, with done=1 in the following cycle.
- start outside IDLE is ignored. in_valid while in_ready=0 is held off; data is not consumed.
- Pipeline (accept edge = E0):
  - E0: register in_vector.
  - E1: register N signed W×W→2W products.
  - E2: combine the rounded product with prev_vector sampled at E2; register result_data; result_write_enable=1 for exactly the cycle after E2.
  - The downstream register captures at E3.
  - The bubble guarantees the next beat's E2 is at or after E3+1, so it reads the committed value (no stale read).
  - Latency: accept → write_enable asserted is 3 cycles. Throughput: one beat per 2 cycles.
- Arithmetic, per lane:
  - p = product + 2^(F-1), arithmetic-shifted right by F (round half up).
  - s = prev ± p, computed at W+2 bits.
  - Result: see Optional Feature.
- result_data holds its value between writes. result_write_enable is never high in two consecutive cycles.

Optional Feature:
Macro MUL_ADD2_SAT_EN.
- Defined:
  - s and p are clamped to [-2^(W-1), 2^(W-1)-1].
  - Any clamp in any lane sets overflow. overflow stays set until rst or the next accepted start.
- Undefined:
  - Results wrap (low W bits of s).
  - overflow is tied 0.

Test Plan:
- Add, beat_count=1, F=16, scalar=0x00020000, subtract=0, lane0 in=0x00018000, prev=0x00010000 → lane0 result 0x00040000. write_enable exactly 3 cycles after accept; done the cycle after write_enable.
- Subtract, same values with subtract=1 → lane0 result 0xFFFE0000. All other lanes with in=0 return prev unchanged.
- Accumulate: prev_vector driven from a real downstream register initialised to 0; beat_count=3, scalar=0x00010000, in_valid held high, all lanes in=0x00010000 → successive writes 0x00010000, 0x00020000, 0x00030000. in_ready pattern 1,0,1,0,1 then 0 in DRAIN.
- Saturation (MUL_ADD2_SAT_EN): prev=0x7FFF0000, scalar=0x00020000, in=0x00010000 → result 0x7FFFFFFF, overflow=1. Without the macro → 0x80010000, overflow=0.
- beat_count=0 start → no write_enable; done high exactly one cycle later; busy never asserts.
- rst asserted in the cycle after the 2nd accept of a 4-beat burst → no further write_enable; all outputs at reset values next cycle. A new start then runs a full burst normally.

Source files
------------

// File: rtl/mul_add2_stage.sv
// mul_add2_stage: lane-parallel fixed-point result = prev +/- scalar*vec feeding the mul_add2 result register.
// Define MUL_ADD2_SAT_EN for saturating arithmetic with a sticky overflow flag; the default build wraps.
module mul_add2_stage #(
  parameter int unsigned number_of_equations_per_cluster = 9,
  parameter int unsigned element_width                   = 32,
  parameter int unsigned frac_bits                       = 16,
  parameter int unsigned count_width                     = 16
) (
  input  logic                                                    clk,
  input  logic                                                    rst,
  input  logic                                                    start,
  input  logic [count_width-1:0]                                  beat_count,
  input  logic [element_width-1:0]                                scalar,
  input  logic                                                    subtract,
  input  logic                                                    in_valid,
  output logic                                                    in_ready,
  input  logic [element_width*number_of_equations_per_cluster-1:0] in_vector,
  input  logic [element_width*number_of_equations_per_cluster-1:0] prev_vector,
  output logic [element_width*number_of_equations_per_cluster-1:0] result_data,
  output logic                                                    result_write_enable,
  output logic                                                    busy,
  output logic                                                    done,
  output logic                                                    overflow
);

  localparam int unsigned N  = number_of_equations_per_cluster;
  localparam int unsigned W  = element_width;
  localparam int unsigned F  = frac_bits;
  localparam int unsigned CW = count_width;
  localparam int unsigned PW = 2 * W;
  localparam int unsigned SW = W + 2;
  localparam int unsigned VW = W * N;

  localparam logic signed [PW:0] RND_HALF = (PW+1)'(1) << (F - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state, next_state;

  logic [CW-1:0]        remaining, remaining_d;
  logic                 in_ready_d, busy_d, done_d, load_cfg;
  logic                 accept_c;
  logic signed [W-1:0]  scalar_q;
  logic                 sub_q;

  logic [VW-1:0]        vec_q;
  logic [N*PW-1:0]      prod_c, prod_q;
  logic [VW-1:0]        res_c;
  logic                 v0, v1, last0, last1, wr_last;

  assign accept_c = in_valid & in_ready;

  // State and registered control outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      remaining <= '0;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= next_state;
      remaining <= remaining_d;
      in_ready  <= in_ready_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

  // Next state; in_ready drops for one cycle after every accept to keep prev reads coherent
  always_comb begin
    next_state  = state;
    remaining_d = remaining;
    done_d      = 1'b0;
    load_cfg    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (beat_count != '0) begin
            next_state  = RUN;
            remaining_d = beat_count;
            load_cfg    = 1'b1;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (accept_c) begin
          remaining_d = remaining - CW'(1);
          if (remaining == CW'(1)) begin
            next_state = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (result_write_enable && wr_last) begin
          next_state = IDLE;
          done_d     = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
    in_ready_d = (next_state == RUN) && !accept_c;
    busy_d     = (next_state != IDLE);
  end

  // Burst configuration, held for the whole burst
  always_ff @(posedge clk) begin
    if (load_cfg) begin
      scalar_q <= scalar;
      sub_q    <= subtract;
    end
  end

  // Data pipeline registers (no reset needed; qualified by valids)
  always_ff @(posedge clk) begin
    if (accept_c) begin
      vec_q <= in_vector;
    end
    if (v0) begin
      prod_q <= prod_c;
    end
  end

`ifdef MUL_ADD2_SAT_EN
  logic [N-1:0] lane_clamp;
`endif

  // Valid pipeline, result register and overflow flag
  always_ff @(posedge clk) begin
    if (rst) begin
      v0                  <= 1'b0;
      v1                  <= 1'b0;
      last0               <= 1'b0;
      last1               <= 1'b0;
      result_write_enable <= 1'b0;
      wr_last             <= 1'b0;
      result_data         <= '0;
      overflow            <= 1'b0;
    end else begin
      v0                  <= accept_c;
      last0               <= accept_c && (remaining == CW'(1));
      v1                  <= v0;
      last1               <= last0;
      result_write_enable <= v1;
      wr_last             <= last1;
      if (v1) begin
        result_data <= res_c;
      end
`ifdef MUL_ADD2_SAT_EN
      overflow <= ((start && (state == IDLE)) ? 1'b0 : overflow) | (v1 & (|lane_clamp));
`else
      overflow <= 1'b0;
`endif
    end
  end

`ifdef MUL_ADD2_SAT_EN
  localparam logic signed [PW:0]   P_MAX = {{(W+2){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [PW:0]   P_MIN = ~P_MAX;
  localparam logic signed [SW-1:0] S_MAX = {3'b000, {(W-1){1'b1}}};
  localparam logic signed [SW-1:0] S_MIN = ~S_MAX;
`endif

  for (genvar g = 0; g < N; g++) begin : g_lane
    logic signed [W-1:0]  lane_in;
    logic signed [W-1:0]  lane_prev;
    logic signed [PW-1:0] lane_prod;
    logic signed [PW:0]   rounded;
    logic signed [PW:0]   p_full;
    logic signed [W-1:0]  p_w;
    logic signed [SW-1:0] s;

    assign lane_in                 = vec_q[W*g +: W];
    assign prod_c[PW*g +: PW]      = PW'(lane_in) * PW'(scalar_q);
    assign lane_prod               = prod_q[PW*g +: PW];
    assign lane_prev               = prev_vector[W*g +: W];
    // Round half up, then drop the fractional bits of the product
    assign rounded                 = {lane_prod[PW-1], lane_prod} + RND_HALF;
    assign p_full                  = rounded >>> F;
    assign s = sub_q ? ({{2{lane_prev[W-1]}}, lane_prev} - {{2{p_w[W-1]}}, p_w})
                     : ({{2{lane_prev[W-1]}}, lane_prev} + {{2{p_w[W-1]}}, p_w});

`ifdef MUL_ADD2_SAT_EN
    logic                p_clamp, s_clamp;
    logic signed [W-1:0] lane_res;

    always_comb begin
      p_clamp = 1'b0;
      p_w     = W'(p_full);
      if (p_full > P_MAX) begin
        p_w     = W'(P_MAX);
        p_clamp = 1'b1;
      end else if (p_full < P_MIN) begin
        p_w     = W'(P_MIN);
        p_clamp = 1'b1;
      end
    end

    always_comb begin
      s_clamp  = 1'b0;
      lane_res = W'(s);
      if (s > S_MAX) begin
        lane_res = W'(S_MAX);
        s_clamp  = 1'b1;
      end else if (s < S_MIN) begin
        lane_res = W'(S_MIN);
        s_clamp  = 1'b1;
      end
    end

    assign res_c[W*g +: W] = lane_res;
    assign lane_clamp[g]   = p_clamp | s_clamp;
`else
    assign p_w             = W'(p_full);
    assign res_c[W*g +: W] = W'(s);
`endif
  end

endmodule

// File: tb/tb_mul_add2_stage.sv
// Directed bench for mul_add2_stage: single beats, accumulation through a model register, zero-length and aborted bursts.
module tb_mul_add2_stage;

  localparam int unsigned N  = 9;
  localparam int unsigned W  = 32;
  localparam int unsigned F  = 16;
  localparam int unsigned CW = 16;
  localparam int unsigned VW = N * W;

  logic          clk, rst, start, subtract, in_valid;
  logic          in_ready, result_write_enable, busy, done, overflow;
  logic [CW-1:0] beat_count;
  logic [W-1:0]  scalar;
  logic [VW-1:0] in_vector, prev_vector, prev_drv, mem, result_data;
  logic          use_mem, mem_clr;
  int            n_cmp, n_bad;

  mul_add2_stage #(
    .number_of_equations_per_cluster(N),
    .element_width(W),
    .frac_bits(F),
    .count_width(CW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .beat_count(beat_count), .scalar(scalar),
    .subtract(subtract), .in_valid(in_valid), .in_ready(in_ready), .in_vector(in_vector),
    .prev_vector(prev_vector), .result_data(result_data),
    .result_write_enable(result_write_enable), .busy(busy), .done(done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Downstream previous-result register
  assign prev_vector = use_mem ? mem : prev_drv;
  always @(posedge clk) begin
    if (mem_clr) mem <= '0;
    else if (result_write_enable) mem <= result_data;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] lane(input logic [VW-1:0] v, input int i);
    return v[W*i +: W];
  endfunction

  task automatic single_beat(input string tag, input logic [W-1:0] sc, input logic sub,
                             input logic [W-1:0] in0, input logic [W-1:0] pv0,
                             input logic [W-1:0] exp0, input logic exp_ovf);
    int lat;
    use_mem = 0;
    @(negedge clk);
    start = 1; beat_count = 1; scalar = sc; subtract = sub;
    @(negedge clk);
    start = 0;
    check({tag, "_busy"}, busy, 1);
    check({tag, "_rdy"}, in_ready, 1);
    in_valid  = 1;
    in_vector = '0;
    in_vector[W-1:0] = in0;
    for (int i = 1; i < N; i++) prev_drv[W*i +: W] = W'(i * 32'h0001_1000);
    prev_drv[W-1:0] = pv0;
    @(negedge clk);
    in_valid = 0;
    check({tag, "_rdy_drain"}, in_ready, 0);
    lat = 1;
    while (!result_write_enable && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, lat, 3);
    check({tag, "_res0"}, lane(result_data, 0), exp0);
    for (int i = 1; i < N; i++)
      check($sformatf("%s_lane%0d", tag, i), lane(result_data, i), W'(i * 32'h0001_1000));
    check({tag, "_ovf"}, overflow, exp_ovf);
    check({tag, "_done_early"}, done, 0);
    @(negedge clk);
    check({tag, "_done"}, done, 1);
    check({tag, "_idle"}, busy, 0);
    check({tag, "_we_single"}, result_write_enable, 0);
    @(negedge clk);
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_ovf_sticky"}, overflow, exp_ovf);
  endtask

  task automatic zero_burst();
    @(negedge clk);
    start = 1; beat_count = 0;
    @(negedge clk);
    start = 0;
    check("zb_done", done, 1);
    check("zb_busy", busy, 0);
    check("zb_we", result_write_enable, 0);
    check("zb_ovf_clr", overflow, 0);
    @(negedge clk);
    check("zb_done_pulse", done, 0);
    check("zb_busy2", busy, 0);
    check("zb_we2", result_write_enable, 0);
  endtask

  task automatic burst3(input string tag);
    int wcnt, b2b, we_k, done_k;
    bit prev_we, done_seen;
    bit exp_rdy [6];
    exp_rdy = '{1, 0, 1, 0, 1, 0};
    use_mem = 1; mem_clr = 1;
    @(negedge clk);
    mem_clr = 0;
    start = 1; beat_count = 3; scalar = 32'h0001_0000; subtract = 0;
    @(negedge clk);
    start = 0; in_valid = 1; in_vector = {N{32'h0001_0000}};
    wcnt = 0; b2b = 0; we_k = -1; done_k = -1; prev_we = 0; done_seen = 0;
    for (int k = 0; k < 14 && !done_seen; k++) begin
      if (k < 6) check($sformatf("%s_rdy%0d", tag, k), in_ready, exp_rdy[k]);
      if (k == 2) begin start = 1; beat_count = 5; end
      else if (k == 3) start = 0;
      if (result_write_enable) begin
        check($sformatf("%s_wr%0d_l0", tag, wcnt), lane(result_data, 0), 32'h0001_0000 * (wcnt + 1));
        check($sformatf("%s_wr%0d_ln", tag, wcnt), lane(result_data, N-1), 32'h0001_0000 * (wcnt + 1));
        if (prev_we) b2b++;
        wcnt++;
        we_k = k;
      end
      if (done) begin done_seen = 1; done_k = k; end
      prev_we = result_write_enable;
      @(negedge clk);
    end
    in_valid = 0;
    check({tag, "_done_seen"}, done_seen, 1);
    check({tag, "_writes"}, wcnt, 3);
    check({tag, "_b2b"}, b2b, 0);
    check({tag, "_done_after_we"}, done_k - we_k, 1);
    check({tag, "_idle"}, busy, 0);
  endtask

  task automatic reset_mid_burst();
    int acc, wes;
    use_mem = 1; mem_clr = 1;
    @(negedge clk);
    mem_clr = 0;
    start = 1; beat_count = 4; scalar = 32'h0001_0000; subtract = 0;
    @(negedge clk);
    start = 0; in_valid = 1; in_vector = {N{32'h0001_0000}};
    acc = 0;
    for (int k = 0; k < 12 && acc < 2; k++) begin
      if (in_valid && in_ready) acc++;
      @(negedge clk);
    end
    check("rst_accepts", acc, 2);
    rst = 1;
    @(negedge clk);
    rst = 0; in_valid = 0;
    check("rst_rdy", in_ready, 0);
    check("rst_data", result_data, 0);
    check("rst_we", result_write_enable, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ovf", overflow, 0);
    wes = 0;
    for (int k = 0; k < 8; k++) begin
      if (result_write_enable || busy) wes++;
      @(negedge clk);
    end
    check("rst_no_wr", wes, 0);
  endtask

  initial begin
    clk = 0; rst = 1; start = 0; subtract = 0; in_valid = 0;
    beat_count = '0; scalar = '0; in_vector = '0; prev_drv = '0;
    use_mem = 0; mem_clr = 1; n_cmp = 0; n_bad = 0;
    repeat (3) @(negedge clk);
    check("init_rdy", in_ready, 0);
    check("init_data", result_data, 0);
    check("init_we", result_write_enable, 0);
    check("init_busy", busy, 0);
    check("init_done", done, 0);
    check("init_ovf", overflow, 0);
    rst = 0; mem_clr = 0;

    single_beat("add", 32'h0002_0000, 1'b0, 32'h0001_8000, 32'h0001_0000, 32'h0004_0000, 1'b0);
    single_beat("sub", 32'h0002_0000, 1'b1, 32'h0001_8000, 32'h0001_0000, 32'hFFFE_0000, 1'b0);
`ifdef MUL_ADD2_SAT_EN
    single_beat("sat", 32'h0002_0000, 1'b0, 32'h0001_0000, 32'h7FFF_0000, 32'h7FFF_FFFF, 1'b1);
`else
    single_beat("wrap", 32'h0002_0000, 1'b0, 32'h0001_0000, 32'h7FFF_0000, 32'h8001_0000, 1'b0);
`endif
    zero_burst();
    burst3("acc");
    reset_mid_burst();
    burst3("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
